// File: rtl/wdcfg_pkg.sv
// Shared definitions for the windowed-watchdog configuration register file:
// register offsets, SERVICE bit positions and the lock FSM state type.
package wdcfg_pkg;

   localparam logic [1:0] REG_FWLEN   = 2'd0;
   localparam logic [1:0] REG_SWLEN   = 2'd1;
   localparam logic [1:0] REG_SERVICE = 2'd2;
   localparam logic [1:0] REG_RSTLMT  = 2'd3;
   localparam logic [1:0] REG_KEY     = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;

   localparam int SRV_INIT      = 3;
   localparam int SRV_WDSRVC    = 2;
   localparam int SRV_FLSTAT_HI = 1;
   localparam int SRV_FLSTAT_LO = 0;

   typedef enum logic [1:0] {
      UNLOCKED  = 2'd0,
      LOCKED    = 2'd1,
      KEY1_SEEN = 2'd2
   } lock_state_t;

endpackage

// File: rtl/wdcfg_regfile_if.sv
// Host bus of the configuration register file. Handshake: a write happens on
// every cycle WREN is high; RDEN samples ABUS and RVALID pulses with RDATA on the next cycle.
interface wdcfg_regfile_if #(
   parameter int AW = 4,
   parameter int DW = 8
);
   logic          WREN;
   logic          RDEN;
   logic [AW-1:0] ABUS;
   logic [DW-1:0] DBUS;
   logic [DW-1:0] RDATA;
   logic          RVALID;

   modport master (output WREN, RDEN, ABUS, DBUS, input RDATA, RVALID);
   modport slave  (input WREN, RDEN, ABUS, DBUS, output RDATA, RVALID);
endinterface

// File: rtl/wdcfg_channel.sv
// One watchdog channel's configuration storage. Window/limit fields and the
// stored SERVICE bits are frozen while locked; the service pulse is not.
module wdcfg_channel
   import wdcfg_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          we,
   input  logic          lock,
   input  logic [1:0]    reg_sel,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] fwlen,
   output logic [DW-1:0] swlen,
   output logic [DW-1:0] rst_lmt,
   output logic          init,
   output logic [1:0]    flstat,
   output logic          wdsrvc
);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         fwlen   <= '0;
         swlen   <= '0;
         rst_lmt <= '0;
         init    <= 1'b0;
         flstat  <= 2'b00;
         wdsrvc  <= 1'b0;
      end else begin
         wdsrvc <= 1'b0;
         if (we) begin
            case (reg_sel)
               REG_FWLEN:  if (!lock) fwlen <= wdata;
               REG_SWLEN:  if (!lock) swlen <= wdata;
               REG_RSTLMT: if (!lock) rst_lmt <= wdata;
               REG_SERVICE: begin
                  wdsrvc <= wdata[SRV_WDSRVC];
                  if (!lock) begin
                     init   <= wdata[SRV_INIT];
                     flstat <= wdata[SRV_FLSTAT_HI:SRV_FLSTAT_LO];
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/wdcfg_regfile.sv
// Multi-channel watchdog configuration register file: address decode, key
// lock FSM, sticky write-error flag and registered readback.
module wdcfg_regfile
   import wdcfg_pkg::*;
#(
   parameter int         NCH       = 2,
   parameter int         DW        = 8,
   parameter logic [7:0] LOCK_CODE = 8'hC3,
   parameter logic [7:0] KEY1      = 8'h55,
   parameter logic [7:0] KEY2      = 8'hAA
) (
   input  logic              CLK,
   input  logic              RST_N,
   wdcfg_regfile_if.slave    bus,
   output logic [NCH*DW-1:0] FWLEN,
   output logic [NCH*DW-1:0] SWLEN,
   output logic [NCH*DW-1:0] RST_LMT,
   output logic [NCH-1:0]    INIT,
   output logic [NCH-1:0]    WDSRVC,
   output logic [2*NCH-1:0]  FLSTAT,
   output logic              LOCKED,
   output lock_state_t       DBG_STATE
);

   localparam int AW = $clog2(NCH) + 3;
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   lock_state_t    st, st_nxt;
   logic           werr, werr_set, werr_clr;
   logic           gsel, ch_ok;
   logic [1:0]     reg_a;
   logic [CW-1:0]  ch;
   logic [NCH-1:0] ch_we;
   logic [DW-1:0]  rd_val;

   assign gsel  = bus.ABUS[AW-1];
   assign reg_a = bus.ABUS[1:0];

   // With a single channel the CH field has no bits at all.
   if (NCH > 1) begin : g_ch
      assign ch = bus.ABUS[AW-2:2];
   end else begin : g_noch
      assign ch = '0;
   end

   assign ch_ok     = int'(ch) < NCH;
   assign LOCKED    = (st != wdcfg_pkg::UNLOCKED);
   assign DBG_STATE = st;

   always_comb begin
      st_nxt   = st;
      werr_set = 1'b0;
      werr_clr = 1'b0;
      ch_we    = '0;
      if (bus.WREN) begin
         if (st == wdcfg_pkg::KEY1_SEEN) begin
            // Only KEY2 may follow KEY1; anything else aborts and is dropped.
            if (gsel && reg_a == REG_KEY && bus.DBUS == DW'(KEY2)) begin
               st_nxt = wdcfg_pkg::UNLOCKED;
            end else begin
               st_nxt   = wdcfg_pkg::LOCKED;
               werr_set = 1'b1;
            end
         end else if (!gsel) begin
            if (!ch_ok) begin
               werr_set = 1'b1;
            end else begin
               for (int c = 0; c < NCH; c++) ch_we[c] = (int'(ch) == c);
               if (LOCKED && reg_a != REG_SERVICE) werr_set = 1'b1;
            end
         end else begin
            case (reg_a)
               REG_KEY: begin
                  if (st == wdcfg_pkg::UNLOCKED) begin
                     if (bus.DBUS == DW'(LOCK_CODE)) st_nxt = wdcfg_pkg::LOCKED;
                  end else if (bus.DBUS == DW'(KEY1)) begin
                     st_nxt = wdcfg_pkg::KEY1_SEEN;
                  end else begin
                     werr_set = 1'b1;
                  end
               end
               REG_STATUS: werr_clr = bus.DBUS[1];
               default:    werr_set = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         st   <= wdcfg_pkg::UNLOCKED;
         werr <= 1'b0;
      end else begin
         st <= st_nxt;
         if (werr_set)      werr <= 1'b1;
         else if (werr_clr) werr <= 1'b0;
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      wdcfg_channel #(.DW(DW)) u_chan (
         .CLK     (CLK),
         .RST_N   (RST_N),
         .we      (ch_we[c]),
         .lock    (LOCKED),
         .reg_sel (reg_a),
         .wdata   (bus.DBUS),
         .fwlen   (FWLEN[c*DW +: DW]),
         .swlen   (SWLEN[c*DW +: DW]),
         .rst_lmt (RST_LMT[c*DW +: DW]),
         .init    (INIT[c]),
         .flstat  (FLSTAT[2*c +: 2]),
         .wdsrvc  (WDSRVC[c])
      );
   end

   // Readback uses current register contents, so a same-cycle write is not visible yet.
   always_comb begin
      rd_val = '0;
      if (!gsel) begin
         for (int c = 0; c < NCH; c++) begin
            if (ch_ok && int'(ch) == c) begin
               case (reg_a)
                  REG_FWLEN:  rd_val = FWLEN[c*DW +: DW];
                  REG_SWLEN:  rd_val = SWLEN[c*DW +: DW];
                  REG_RSTLMT: rd_val = RST_LMT[c*DW +: DW];
                  default: begin
                     rd_val[SRV_INIT] = INIT[c];
                     rd_val[SRV_FLSTAT_HI:SRV_FLSTAT_LO] = FLSTAT[2*c +: 2];
                  end
               endcase
            end
         end
      end else if (reg_a == REG_STATUS) begin
         rd_val[1] = werr;
         rd_val[0] = LOCKED;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bus.RDATA  <= '0;
         bus.RVALID <= 1'b0;
      end else begin
         bus.RVALID <= bus.RDEN;
         if (bus.RDEN) bus.RDATA <= rd_val;
      end
   end

endmodule

// File: tb/tb_wdcfg_regfile.sv
// Bench for wdcfg_regfile: a 2-channel and a 3-channel instance driven by
// directed writes and reads; read data is checked through expected queues.
module tb_wdcfg_regfile;
   import wdcfg_pkg::*;

   localparam int DW  = 8;
   localparam int AWA = 4;
   localparam int AWB = 5;

   // clock / reset
   logic CLK   = 1'b0;
   logic RST_N = 1'b1;
   always #5 CLK = ~CLK;

   wdcfg_regfile_if #(.AW(AWA), .DW(DW)) bus_a ();
   wdcfg_regfile_if #(.AW(AWB), .DW(DW)) bus_b ();

   logic [2*DW-1:0] fw_a, sw_a, rl_a;
   logic [1:0]      init_a, srv_a;
   logic [3:0]      fl_a;
   logic            lock_a;
   lock_state_t     dbg_a;

   logic [3*DW-1:0] fw_b, sw_b, rl_b;
   logic [2:0]      init_b, srv_b;
   logic [5:0]      fl_b;
   logic            lock_b;
   lock_state_t     dbg_b;

   wdcfg_regfile #(.NCH(2), .DW(DW)) u_dut_a (
      .CLK(CLK), .RST_N(RST_N), .bus(bus_a),
      .FWLEN(fw_a), .SWLEN(sw_a), .RST_LMT(rl_a), .INIT(init_a),
      .WDSRVC(srv_a), .FLSTAT(fl_a), .LOCKED(lock_a), .DBG_STATE(dbg_a)
   );

   wdcfg_regfile #(.NCH(3), .DW(DW)) u_dut_b (
      .CLK(CLK), .RST_N(RST_N), .bus(bus_b),
      .FWLEN(fw_b), .SWLEN(sw_b), .RST_LMT(rl_b), .INIT(init_b),
      .WDSRVC(srv_b), .FLSTAT(fl_b), .LOCKED(lock_b), .DBG_STATE(dbg_b)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [DW-1:0] exp_qa[$];
   logic [DW-1:0] exp_qb[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // scoreboard monitors
   always @(negedge CLK) begin : mon_a
      logic [DW-1:0] e;
      if (bus_a.RVALID === 1'b1) begin
         n_tests++;
         if (exp_qa.size() == 0) begin
            n_fail++;
            $display("FAIL rd_a: unexpected RVALID with data %0h", bus_a.RDATA);
         end else begin
            e = exp_qa.pop_front();
            if (bus_a.RDATA !== e) begin
               n_fail++;
               $display("FAIL rd_a: got %0h expected %0h", bus_a.RDATA, e);
            end
         end
      end
   end

   always @(negedge CLK) begin : mon_b
      logic [DW-1:0] e;
      if (bus_b.RVALID === 1'b1) begin
         n_tests++;
         if (exp_qb.size() == 0) begin
            n_fail++;
            $display("FAIL rd_b: unexpected RVALID with data %0h", bus_b.RDATA);
         end else begin
            e = exp_qb.pop_front();
            if (bus_b.RDATA !== e) begin
               n_fail++;
               $display("FAIL rd_b: got %0h expected %0h", bus_b.RDATA, e);
            end
         end
      end
   end

   // driver tasks: entered 1ns after a rising edge, return 1ns after the next one
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic wr_a(input logic [AWA-1:0] a, input logic [DW-1:0] d);
      bus_a.WREN = 1'b1; bus_a.ABUS = a; bus_a.DBUS = d;
      @(posedge CLK);
      #1;
      bus_a.WREN = 1'b0;
   endtask

   task automatic rd_a(input logic [AWA-1:0] a, input logic [DW-1:0] e);
      exp_qa.push_back(e);
      bus_a.RDEN = 1'b1; bus_a.ABUS = a;
      @(posedge CLK);
      #1;
      bus_a.RDEN = 1'b0;
      chk("rvalid_a", 32'(bus_a.RVALID), 32'd1);
   endtask

   task automatic wr_b(input logic [AWB-1:0] a, input logic [DW-1:0] d);
      bus_b.WREN = 1'b1; bus_b.ABUS = a; bus_b.DBUS = d;
      @(posedge CLK);
      #1;
      bus_b.WREN = 1'b0;
   endtask

   task automatic rd_b(input logic [AWB-1:0] a, input logic [DW-1:0] e);
      exp_qb.push_back(e);
      bus_b.RDEN = 1'b1; bus_b.ABUS = a;
      @(posedge CLK);
      #1;
      bus_b.RDEN = 1'b0;
   endtask

   task automatic wrrd_b(input logic [AWB-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] e);
      exp_qb.push_back(e);
      bus_b.WREN = 1'b1; bus_b.RDEN = 1'b1; bus_b.ABUS = a; bus_b.DBUS = d;
      @(posedge CLK);
      #1;
      bus_b.WREN = 1'b0; bus_b.RDEN = 1'b0;
   endtask

   localparam logic [AWA-1:0] A_FW0 = 4'b0000, A_SW0 = 4'b0001, A_SV0 = 4'b0010;
   localparam logic [AWA-1:0] A_FW1 = 4'b0100, A_SW1 = 4'b0101, A_SV1 = 4'b0110;
   localparam logic [AWA-1:0] A_RL1 = 4'b0111, A_KEY = 4'b1000, A_STAT = 4'b1001;
   localparam logic [AWA-1:0] A_RSV = 4'b1010;
   localparam logic [AWB-1:0] B_FW2 = 5'b01000, B_FW3 = 5'b01100, B_SV3 = 5'b01110;
   localparam logic [AWB-1:0] B_STAT = 5'b10001;

   initial begin
      bus_a.WREN = 1'b0; bus_a.RDEN = 1'b0; bus_a.ABUS = '0; bus_a.DBUS = '0;
      bus_b.WREN = 1'b0; bus_b.RDEN = 1'b0; bus_b.ABUS = '0; bus_b.DBUS = '0;
      #1 RST_N = 1'b0;
      #11;
      chk("rst_fwlen", 32'(fw_a), 32'h0);
      chk("rst_locked", 32'(lock_a), 32'h0);
      chk("rst_rvalid", 32'(bus_a.RVALID), 32'h0);
      chk("rst_rdata", 32'(bus_a.RDATA), 32'h0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;

      // channel 1 window/limit writes and readback
      wr_a(A_FW1, 8'h20);
      wr_a(A_SW1, 8'h40);
      wr_a(A_RL1, 8'h03);
      chk("fwlen_ch1", 32'(fw_a), 32'h2000);
      chk("swlen_ch1", 32'(sw_a), 32'h4000);
      chk("rstlmt_ch1", 32'(rl_a), 32'h0300);
      rd_a(A_FW0, 8'h00);
      rd_a(A_FW1, 8'h20);
      rd_a(A_SW1, 8'h40);
      rd_a(A_RL1, 8'h03);
      idle(1);
      chk("rvalid_idle", 32'(bus_a.RVALID), 32'h0);
      chk("rdata_hold", 32'(bus_a.RDATA), 32'h03);

      // SERVICE: stored bits and service pulses
      wr_a(A_SV0, 8'h0D);
      chk("init_ch0", 32'(init_a), 32'h1);
      chk("flstat_ch0", 32'(fl_a), 32'h1);
      chk("srv_pulse", 32'(srv_a), 32'h1);
      idle(1);
      chk("srv_end", 32'(srv_a), 32'h0);
      rd_a(A_SV0, 8'h09);
      wr_a(A_SV1, 8'h04);
      chk("srv_b2b_1", 32'(srv_a), 32'h2);
      wr_a(A_SV1, 8'h04);
      chk("srv_b2b_2", 32'(srv_a), 32'h2);
      idle(1);
      chk("srv_b2b_end", 32'(srv_a), 32'h0);
      wr_a(A_KEY, 8'h55);
      chk("key_ignored", 32'(lock_a), 32'h0);
      rd_a(A_STAT, 8'h00);
      rd_a(A_KEY, 8'h00);

      // lock and protected writes
      wr_a(A_KEY, 8'hC3);
      chk("locked", 32'(lock_a), 32'h1);
      wr_a(A_FW0, 8'h77);
      chk("fwlen_locked", 32'(fw_a), 32'h2000);
      rd_a(A_STAT, 8'h03);
      wr_a(A_SV0, 8'h04);
      chk("srv_locked", 32'(srv_a), 32'h1);
      chk("init_frozen", 32'(init_a), 32'h1);
      chk("flstat_frozen", 32'(fl_a), 32'h1);
      rd_a(A_SV0, 8'h09);

      // unlock sequence, aborted and completed
      wr_a(A_STAT, 8'h02);
      rd_a(A_STAT, 8'h01);
      wr_a(A_KEY, 8'h55);
      chk("st_key1", 32'(dbg_a), 32'(KEY1_SEEN));
      wr_a(A_SW0, 8'h11);
      chk("swlen_abort", 32'(sw_a), 32'h4000);
      chk("st_abort", 32'(dbg_a), 32'(wdcfg_pkg::LOCKED));
      wr_a(A_KEY, 8'hAA);
      rd_a(A_STAT, 8'h03);
      wr_a(A_KEY, 8'h55);
      idle(2);
      wr_a(A_KEY, 8'hAA);
      chk("unlocked", 32'(lock_a), 32'h0);
      rd_a(A_STAT, 8'h02);
      wr_a(A_STAT, 8'h02);
      rd_a(A_STAT, 8'h00);
      wr_a(A_FW0, 8'h77);
      chk("fwlen_unlocked", 32'(fw_a), 32'h2077);
      wr_a(A_RSV, 8'h5A);
      rd_a(A_RSV, 8'h00);
      rd_a(A_STAT, 8'h02);

      // asynchronous reset while in KEY1_SEEN
      wr_a(A_KEY, 8'hC3);
      wr_a(A_KEY, 8'h55);
      chk("st_key1_pre_rst", 32'(dbg_a), 32'(KEY1_SEEN));
      #2 RST_N = 1'b0;
      #1;
      chk("arst_fwlen", 32'(fw_a), 32'h0);
      chk("arst_swlen", 32'(sw_a), 32'h0);
      chk("arst_rstlmt", 32'(rl_a), 32'h0);
      chk("arst_init", 32'(init_a), 32'h0);
      chk("arst_flstat", 32'(fl_a), 32'h0);
      chk("arst_srv", 32'(srv_a), 32'h0);
      chk("arst_locked", 32'(lock_a), 32'h0);
      chk("arst_state", 32'(dbg_a), 32'(UNLOCKED));
      chk("arst_rdata", 32'(bus_a.RDATA), 32'h0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
      chk("post_rst_srv0", 32'(srv_a), 32'h0);
      idle(1);
      chk("post_rst_srv1", 32'(srv_a), 32'h0);
      rd_a(A_STAT, 8'h00);

      // three-channel instance: out-of-range channel and read-during-write
      wr_b(B_FW3, 8'h5A);
      chk("b_fwlen_untouched", 32'(fw_b), 32'h0);
      rd_b(B_STAT, 8'h02);
      rd_b(B_FW3, 8'h00);
      rd_b(B_SV3, 8'h00);
      wr_b(B_FW2, 8'h11);
      chk("b_fwlen_ch2", 32'(fw_b), 32'h110000);
      wrrd_b(B_FW2, 8'h22, 8'h11);
      chk("b_fwlen_ch2_new", 32'(fw_b), 32'h220000);
      rd_b(B_FW2, 8'h22);

      idle(2);
      chk("drain_a", 32'(exp_qa.size()), 32'h0);
      chk("drain_b", 32'(exp_qb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wdcfg_regfile.md
Name: wdcfg_regfile

Overview:
Parametrised, multi-channel configuration register file for the windowed watchdog cores. It holds per-channel first/second window lengths, reset limit and service/control fields. It adds three things: a key-protected lock FSM, registered readback and a sticky write-error flag. It sits between the host bus and NCH watchdog channel instances.

Parameters:
NCH, 2, number of watchdog channels (1..8)
DW, 8, data/register width (>=8)
LOCK_CODE, 8'hC3, value written to KEY that locks the file
KEY1, 8'h55, first unlock key
KEY2, 8'hAA, second unlock key
AW (derived), $clog2(NCH)+3, address width: {GSEL, CH[$clog2(NCH)-1:0], REG[1:0]}; treat CH as 0 bits when NCH=1

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  reset, asynchronous, active-low
WREN  in  1  write strobe, one write per asserted cycle
RDEN  in  1  read strobe
ABUS  in  AW  address
DBUS  in  DW  write data
RDATA  out  DW  read data, registered
RVALID  out  1  1-cycle pulse, RDATA valid
FWLEN  out  NCH*DW  first window length, channel c at [c*DW +: DW]
SWLEN  out  NCH*DW  second window length
RST_LMT  out  NCH*DW  reset limit
INIT  out  NCH  channel init enable (SERVICE[3])
WDSRVC  out  NCH  one-cycle service pulse per channel
FLSTAT  out  2*NCH  fail status field (SERVICE[1:0])
LOCKED  out  1  1 when the lock FSM is in LOCKED or KEY1_SEEN

Behaviour:
- Reset (async assert, sync release): all channel registers 0, all outputs 0, FSM=UNLOCKED, WERR=0.
- Address map for GSEL=0: REG 0=FWLEN, 1=SWLEN, 2=SERVICE, 3=RST_LMT of channel CH.
- Address map for GSEL=1: REG 0=KEY (write-only, reads 0), 1=STATUS {0.., WERR, LOCKED}. REG 2 and 3 are reserved: reads return 0; writes are ignored and set WERR.
- Channel-register writes take effect on the clock edge after WREN; outputs update the same edge.
- SERVICE[3] (INIT) and SERVICE[1:0] (FLSTAT) are stored.
- SERVICE[2] is not stored. Writing 1 to it produces a 1-cycle WDSRVC pulse for that channel on the next cycle. Consecutive service writes give consecutive pulses. SERVICE bit 2 reads back 0.
- Lock FSM states: UNLOCKED, LOCKED, KEY1_SEEN.
  - UNLOCKED: a KEY write of LOCK_CODE goes to LOCKED. Any other KEY value is ignored (no error).
  - LOCKED: a KEY write of KEY1 goes to KEY1_SEEN. Any other KEY write sets WERR.
  - KEY1_SEEN: the very next WREN cycle must be a KEY write of KEY2, which goes to UNLOCKED. Any other WREN cycle goes back to LOCKED, sets WERR, and that write is itself discarded. Idle cycles do not abort.
- While LOCKED or KEY1_SEEN:
  - Writes to FWLEN, SWLEN and RST_LMT are discarded and set WERR.
  - A SERVICE write still generates the WDSRVC pulse, but INIT/FLSTAT are not updated. No WERR is raised.
- Out-of-range channel (CH>=NCH): writes are discarded and set WERR; reads return 0.
- STATUS write with DBUS[1]=1 clears WERR. If an error event happens in the same cycle, the set wins. This write is allowed in any FSM state.
- Read path: RDEN samples ABUS; RDATA and RVALID appear the next cycle. With no read, RVALID=0 and RDATA holds its value.
- Simultaneous RDEN and WREN to the same address: the read returns the pre-write value.
- Reset asserted mid-sequence (e.g. in KEY1_SEEN) returns the FSM to UNLOCKED immediately.

Decomposition:
- Package wdcfg_pkg holds:
  - register offsets REG_FWLEN/REG_SWLEN/REG_SERVICE/REG_RSTLMT, REG_KEY/REG_STATUS;
  - SERVICE bit positions (INIT=3, WDSRVC=2, FLSTAT=1:0);
  - lock_state_t enum {UNLOCKED, LOCKED, KEY1_SEEN}.
- Sub-module wdcfg_channel: one channel's FWLEN/SWLEN/RST_LMT/SERVICE storage and WDSRVC pulse logic. It takes a per-channel write enable and a lock input, and is generated NCH times. The top level owns address decode, lock FSM, WERR and readback mux.

Test Plan:
- Reset then write ch1 FWLEN=8'h20, SWLEN=8'h40, RST_LMT=8'h03 -> FWLEN[15:8]=20, SWLEN[15:8]=40, RST_LMT[15:8]=03; ch0 fields stay 0; readback returns the same values with RVALID one cycle after RDEN.
- Write ch0 SERVICE=8'h0D -> INIT[0]=1, FLSTAT[1:0]=01, WDSRVC[0] high exactly 1 cycle; SERVICE reads back 8'h09.
- KEY=C3 then write ch0 FWLEN=8'h77 -> FWLEN[7:0] unchanged, STATUS=8'h03 (WERR=1, LOCKED=1); a ch0 SERVICE=8'h04 write still pulses WDSRVC[0].
- While locked: KEY=55, then SWLEN write, then KEY=AA -> still LOCKED, WERR=1. Then KEY=55 followed by KEY=AA -> LOCKED=0. STATUS write 8'h02 -> WERR=0.
- Assert RST_N=0 asynchronously (between clock edges) while in KEY1_SEEN -> all outputs 0 and LOCKED=0 before the next clock edge; no spurious WDSRVC after release.
- NCH=3: write to CH=3 -> WERR=1, reads of CH=3 return 0; same-cycle WREN+RDEN on ch2 FWLEN returns the old value, and a follow-up read returns the new value.
